// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

   localparam int unsigned DEFAULT_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mult_sign_adj.sv
// Conditional two's-complement: passes i_val through, or negates it when i_neg is set.
module mult_sign_adj #(
   parameter int unsigned WIDTH = 12
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_val
);

   always_comb begin
      o_val = i_val;
      if (i_neg) begin
         o_val = ~i_val + WIDTH'(1);
      end
   end

endmodule

// File: rtl/multiplier_seq.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// sign applied to the final product. Valid/ready handshakes on both sides.
module multiplier_seq
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     num1,
   input  logic [WIDTH-1:0]     num2,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [PW-1:0]      r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [PW-1:0]      r_acc;
   logic               r_sign;
   logic [PW-1:0]      r_result;

   logic               w_neg1;
   logic               w_neg2;
   logic [WIDTH-1:0]   w_mag1;
   logic [WIDTH-1:0]   w_mag2;
   logic [PW-1:0]      w_addend;
   logic [PW-1:0]      w_acc_nxt;
   logic [PW-1:0]      w_prod;
   logic               w_last;

   assign w_neg1 = signed_mode & num1[WIDTH-1];
   assign w_neg2 = signed_mode & num2[WIDTH-1];

   // Magnitude of the most-negative value fits as unsigned in WIDTH bits.
   mult_sign_adj #(.WIDTH(WIDTH)) u_abs1 (
      .i_val (num1),
      .i_neg (w_neg1),
      .o_val (w_mag1)
   );

   mult_sign_adj #(.WIDTH(WIDTH)) u_abs2 (
      .i_val (num2),
      .i_neg (w_neg2),
      .o_val (w_mag2)
   );

   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_nxt = r_acc + w_addend;
   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

   mult_sign_adj #(.WIDTH(PW)) u_prod_neg (
      .i_val (w_acc_nxt),
      .i_neg (r_sign),
      .o_val (w_prod)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = CALC;
         CALC:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_sign   <= 1'b0;
         r_result <= '0;
      end else begin
         if (r_state == IDLE && in_valid) begin
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_sign   <= w_neg1 ^ w_neg2;
         end else if (r_state == CALC) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_nxt;
            if (w_last) begin
               r_result <= w_prod;
            end
         end
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign result    = r_result;

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench: vector table plus hand sequences at WIDTH=12, random sweep at 8 and 16.
module tb_multiplier_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // WIDTH=12 instance
   logic          iv12 = 1'b0, sm12 = 1'b0, ordy12 = 1'b1;
   logic [11:0]   a12 = '0, b12 = '0;
   logic          ir12, ov12, busy12;
   logic [23:0]   res12;

   // WIDTH=8 and WIDTH=16 instances share control inputs
   logic          iv_s = 1'b0, sm_s = 1'b0, ordy_s = 1'b1;
   logic [7:0]    a8 = '0, b8 = '0;
   logic [15:0]   a16 = '0, b16 = '0;
   logic          ir8, ov8, busy8, ir16, ov16, busy16;
   logic [15:0]   res8;
   logic [31:0]   res16;

   multiplier_seq #(.WIDTH(12)) u_dut12 (
      .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12), .num1(a12), .num2(b12),
      .signed_mode(sm12), .out_valid(ov12), .out_ready(ordy12), .result(res12), .busy(busy12)
   );
   multiplier_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir8), .num1(a8), .num2(b8),
      .signed_mode(sm_s), .out_valid(ov8), .out_ready(ordy_s), .result(res8), .busy(busy8)
   );
   multiplier_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir16), .num1(a16), .num2(b16),
      .signed_mode(sm_s), .out_valid(ov16), .out_ready(ordy_s), .result(res16), .busy(busy16)
   );

   logic [63:0] q12[$];
   logic [63:0] q8[$];
   logic [63:0] q16[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
      logic signed [63:0] sa, sb, p;
      sa = {32'b0, a};
      sb = {32'b0, b};
      if (s) begin
         sa = sa <<< (64 - w);
         sa = sa >>> (64 - w);
         sb = sb <<< (64 - w);
         sb = sb >>> (64 - w);
      end
      p = sa * sb;
      return p & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Output monitors: latency from accept edge and scoreboard pop on handshake
   int   acc12 = 0, acc8 = 0, acc16 = 0;
   logic ov12_d = 1'b0, ov8_d = 1'b0, ov16_d = 1'b0;

   always @(negedge clk) begin
      if (!rst && iv12 && ir12) acc12 = cyc + 1;
      if (!rst && ov12 && !ov12_d) check("latency12", 64'(cyc - acc12), 64'd12);
      ov12_d = ov12;
      if (!rst && ov12 && ordy12) begin
         if (q12.size() == 0) check("sb12_unexpected", 64'd1, 64'd0);
         else check("result12", res12, q12.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && iv_s && ir8) acc8 = cyc + 1;
      if (!rst && iv_s && ir16) acc16 = cyc + 1;
      if (!rst && ov8 && !ov8_d) check("latency8", 64'(cyc - acc8), 64'd8);
      if (!rst && ov16 && !ov16_d) check("latency16", 64'(cyc - acc16), 64'd16);
      ov8_d  = ov8;
      ov16_d = ov16;
      if (!rst && ov8 && ordy_s) begin
         if (q8.size() == 0) check("sb8_unexpected", 64'd1, 64'd0);
         else check("result8", res8, q8.pop_front());
      end
      if (!rst && ov16 && ordy_s) begin
         if (q16.size() == 0) check("sb16_unexpected", 64'd1, 64'd0);
         else check("result16", res16, q16.pop_front());
      end
   end

   task automatic issue12(input logic [11:0] a, input logic [11:0] b, input logic s,
                          input logic [63:0] exp);
      for (int i = 0; i < 60 && !ir12; i++) begin
         @(posedge clk); #1;
      end
      a12 = a; b12 = b; sm12 = s; iv12 = 1'b1;
      q12.push_back(exp);
      @(posedge clk); #1;
      iv12 = 1'b0;
   endtask

   task automatic issue_s(input logic [7:0] x8, input logic [7:0] y8, input logic [15:0] x16,
                          input logic [15:0] y16, input logic s);
      for (int i = 0; i < 60 && !(ir8 && ir16); i++) begin
         @(posedge clk); #1;
      end
      a8 = x8; b8 = y8; a16 = x16; b16 = y16; sm_s = s; iv_s = 1'b1;
      q8.push_back(ref_mul({24'b0, x8}, {24'b0, y8}, s, 8));
      q16.push_back(ref_mul({16'b0, x16}, {16'b0, y16}, s, 16));
      @(posedge clk); #1;
      iv_s = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((q12.size() + q8.size() + q16.size()) != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(q12.size() + q8.size() + q16.size()), 64'd0);
   endtask

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        s;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] exp;
      int          seen;

      vecs[0] = '{12'hAB2, 12'hC71, 1'b0, 24'h851092};
      vecs[1] = '{12'hAB2, 12'hC71, 1'b1, 24'h12E092};
      vecs[2] = '{12'hFFF, 12'h001, 1'b1, 24'hFFFFFF};
      vecs[3] = '{12'hFFF, 12'hFFF, 1'b0, 24'hFFE001};
      vecs[4] = '{12'h800, 12'h800, 1'b1, 24'h400000};
      vecs[5] = '{12'h800, 12'h800, 1'b0, 24'h400000};
      vecs[6] = '{12'h7FF, 12'h800, 1'b1, 24'hC00800};
      vecs[7] = '{12'h000, 12'h800, 1'b1, 24'h000000};
      vecs[8] = '{12'hAB2, 12'h001, 1'b1, 24'hFFFAB2};
      vecs[9] = '{12'h001, 12'hAB2, 1'b0, 24'h000AB2};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", ir12, 1'b1);
      check("rst_out_valid", ov12, 1'b0);
      check("rst_busy", busy12, 1'b0);
      check("rst_result", res12, 24'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Vector table, including the zero operand case which must still take full latency
      for (int i = 0; i < 10; i++) begin
         issue12(vecs[i].a, vecs[i].b, vecs[i].s, {40'b0, vecs[i].exp});
         drain("table_drain");
      end

      // Operand churn and ignored in_valid during CALC
      issue12(12'h5A5, 12'h3C3, 1'b1, ref_mul(32'h5A5, 32'h3C3, 1'b1, 12));
      for (int i = 0; i < 8; i++) begin
         a12 = 12'($urandom); b12 = 12'($urandom); sm12 = 1'($urandom); iv12 = 1'b1;
         check("calc_in_ready", ir12, 1'b0);
         @(posedge clk); #1;
      end
      iv12 = 1'b0;
      drain("churn_drain");

      // Backpressure: result held, no capture while DONE
      ordy12 = 1'b0;
      exp = ref_mul(32'h123, 32'h456, 1'b0, 12);
      issue12(12'h123, 12'h456, 1'b0, exp);
      for (int i = 0; i < 40 && !ov12; i++) begin
         @(posedge clk); #1;
      end
      check("bp_out_valid", ov12, 1'b1);
      for (int i = 0; i < 5; i++) begin
         a12 = 12'($urandom); b12 = 12'($urandom); iv12 = 1'(i);
         @(posedge clk); #1;
         check("bp_result_stable", res12, exp[23:0]);
         check("bp_in_ready", ir12, 1'b0);
         check("bp_still_valid", ov12, 1'b1);
      end
      iv12 = 1'b0;
      ordy12 = 1'b1;
      @(posedge clk); #1;
      check("bp_back_idle", ir12, 1'b1);
      check("bp_result_retained", res12, exp[23:0]);
      @(posedge clk); #1;
      check("bp_no_capture", busy12, 1'b0);
      drain("bp_drain");

      // Reset at counter=5 aborts the operation
      issue12(12'h9C4, 12'h2B7, 1'b0, ref_mul(32'h9C4, 32'h2B7, 1'b0, 12));
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      q12.delete();
      check("abort_in_ready", ir12, 1'b1);
      check("abort_busy", busy12, 1'b0);
      check("abort_out_valid", ov12, 1'b0);
      check("abort_result", res12, 24'h0);
      seen = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (ov12) seen++;
      end
      check("abort_no_stale_valid", 64'(seen), 64'd0);

      // Parameter sweep at WIDTH=8 and WIDTH=16
      for (int i = 0; i < 12; i++) begin
         if (i == 0) issue_s(8'h80, 8'h80, 16'h8000, 16'h8000, 1'b1);
         else if (i == 1) issue_s(8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 1'b0);
         else issue_s(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
         drain("sweep_drain");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 12, giving operand width in bits (legal range 4..32).
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide; reset SHALL be synchronous and active-high.
REQ-004 Port in_valid SHALL be an input, 1 bit wide, indicating that the operands are valid.
REQ-005 Port in_ready SHALL be an output, 1 bit wide, indicating that the block can accept operands.
REQ-006 Ports num1 and num2 SHALL be inputs, WIDTH bits each, carrying the operands.
REQ-007 Port signed_mode SHALL be an input, 1 bit wide, sampled with the operands; 1 means two's-complement, 0 means unsigned.
REQ-008 Port out_valid SHALL be an output, 1 bit wide, indicating that result is valid.
REQ-009 Port out_ready SHALL be an input, 1 bit wide, driven by the consumer to accept result.
REQ-010 Port result SHALL be an output, 2*WIDTH bits wide, carrying the full-precision product.
REQ-011 Port busy SHALL be an output, 1 bit wide, high in every state except IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 in_ready SHALL equal 1 exactly when the state is IDLE.
REQ-014 An input handshake (in_valid & in_ready at a rising edge) SHALL capture num1, num2 and signed_mode and SHALL move the FSM to CALC.
- Signed mode: operand magnitudes and the sign flag (sign(num1) XOR sign(num2)) are stored.
REQ-015 CALC SHALL perform radix-2 shift-add, one multiplier bit per cycle, using a bit counter that runs 0..WIDTH-1.
REQ-016 At the edge where the counter equals WIDTH-1, the FSM SHALL enter DONE and register the sign-corrected product into result.
- Net latency: out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-017 out_valid SHALL be 1 only in DONE; result SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 An output handshake (out_valid & out_ready) SHALL return the FSM to IDLE on that edge.
REQ-019 in_valid asserted outside IDLE SHALL be ignored, with no capture and no side effect.
REQ-020 Operand changes during CALC SHALL NOT affect the in-flight product.
REQ-021 Signed most-negative operands SHALL produce the correct result; the magnitude 2^(WIDTH-1) is held in WIDTH bits as unsigned.
- Example: -2^(W-1) * -2^(W-1) = +2^(2W-2).
REQ-022 Unsigned mode SHALL produce num1*num2 exactly, and never overflows 2*WIDTH bits.
REQ-023 result SHALL retain the last product after the output handshake, until the next DONE entry.
REQ-024 A zero operand SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-025 While rst=1 at a rising edge, the state SHALL become IDLE, and the counter, accumulator, result and sign flag SHALL clear to 0.
REQ-026 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, result=0.
REQ-027 rst asserted mid-CALC or in DONE SHALL abort the operation on that edge; no out_valid pulse SHALL follow.
REQ-028 rst SHALL take priority over any simultaneous input or output handshake.

Structure
REQ-029 Package mult_pkg SHALL hold the state enum type (IDLE/CALC/DONE) and the localparam default width 12.
REQ-030 A single sub-module, mult_sign_adj, SHALL implement conditional two's-complement (abs/negate) parametrised by width.
- It is instantiated for operand magnitude conversion and for final product negation.
REQ-031 The counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-032 Unsigned, WIDTH=12: num1=0xAB2, num2=0xC71, signed_mode=0, out_ready=1 -> result=0x851092, out_valid high 12 cycles after accept.
REQ-033 Signed, WIDTH=12: num1=0xAB2 (-1358), num2=0xC71 (-911) -> result=0x12E092.
REQ-034 Extremes, WIDTH=12: signed 0xFFF*0x001 -> 0xFFFFFF; unsigned 0xFFF*0xFFF -> 0xFFE001; signed 0x800*0x800 -> 0x400000.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after DONE, toggle num1/num2/in_valid -> result stable, in_ready=0, no new capture; product accepted when out_ready=1.
REQ-036 Reset mid-operation: assert rst at counter=5 -> next cycle in_ready=1, busy=0, out_valid=0, result=0; no stale out_valid.
REQ-037 Parameter sweep: WIDTH=8 and WIDTH=16 with random signed/unsigned pairs -> result matches reference product, latency equals WIDTH cycles.
